// File: rtl/seg_scan_capture.sv
// seg_scan_capture: rebuilds the 6-digit hex value shown on a multiplexed active-low 7-segment scan.
// Optional macro SEG_DP_CAPTURE_EN adds dp_out and makes the decoder ignore the dp bit.
module seg_scan_capture #(
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg_in,
  input  logic [2:0]  sel_in,
  output logic [23:0] data_out,
  output logic        data_valid,
  output logic        seg_err,
  output logic        frame_err
`ifdef SEG_DP_CAPTURE_EN
  ,
  output logic [5:0]  dp_out
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, WAIT_CHANGE} state_e;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic [7:0]  seg_sync_q [SYNC_STAGES];
  logic [2:0]  sel_sync_q [SYNC_STAGES];
  logic [7:0]  seg_s, seg_dly_q;
  logic [2:0]  sel_s, sel_dly_q;
  logic        change;

  state_e      state_q, state_d;
  logic [2:0]  exp_idx_q, exp_idx_d;
  logic [2:0]  samp_sel_q, samp_sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] frame_q, frame_d, merged;
  logic [23:0] data_q, data_d;
  logic        valid_q, valid_d, seg_err_q, seg_err_d, frame_err_q, frame_err_d;
  logic        clr_frame, wr_part, load_out;
  logic [4:0]  dec;

  // Returns {valid, nibble}; an unknown pattern yields valid = 0.
  function automatic logic [4:0] decode(input logic [7:0] pat);
    logic [7:0] key;
    logic [4:0] res;
`ifdef SEG_DP_CAPTURE_EN
    key = {1'b1, pat[6:0]};
`else
    key = pat;
`endif
    res = 5'b0;
    for (int i = 0; i < 16; i++)
      if (key == SEG_TABLE[i]) res = {1'b1, 4'(i)};
    return res;
  endfunction

  // Synchronizers reset to a blank display on select 0 so no stale digit is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        seg_sync_q[i] <= '1;
        sel_sync_q[i] <= '0;
      end
      seg_dly_q <= '1;
      sel_dly_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
      seg_sync_q[0] <= seg_in;
      sel_sync_q[0] <= sel_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        seg_sync_q[i] <= seg_sync_q[i-1];
        sel_sync_q[i] <= sel_sync_q[i-1];
      end
      seg_dly_q <= seg_s;
      sel_dly_q <= sel_s;
    end
  end

  assign seg_s  = seg_sync_q[SYNC_STAGES-1];
  assign sel_s  = sel_sync_q[SYNC_STAGES-1];
  assign change = (seg_s != seg_dly_q) || (sel_s != sel_dly_q);
  assign dec    = decode(seg_dly_q);

  always_comb begin
    merged = frame_q;
    for (int i = 0; i < 6; i++)
      if (exp_idx_q == 3'(i)) merged[4*(5-i) +: 4] = dec[3:0];
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    exp_idx_d   = exp_idx_q;
    samp_sel_d  = samp_sel_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    seg_err_d   = 1'b0;
    frame_err_d = 1'b0;
    clr_frame   = 1'b0;
    wr_part     = 1'b0;
    load_out    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_s == 3'd0) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if ((sel_s != sel_dly_q) && (sel_s != exp_idx_q)) begin
          frame_err_d = (exp_idx_q != 3'd0);
          clr_frame   = 1'b1;
          exp_idx_d   = '0;
          state_d     = IDLE;
        end else if (change) begin
          cnt_d = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SAMPLE: begin
        samp_sel_d = sel_dly_q;
        if (!dec[4]) begin
          seg_err_d = 1'b1;
          clr_frame = 1'b1;
          exp_idx_d = '0;
          state_d   = IDLE;
        end else if (exp_idx_q == 3'd5) begin
          load_out  = 1'b1;
          valid_d   = 1'b1;
          clr_frame = 1'b1;
          exp_idx_d = '0;
          state_d   = WAIT_CHANGE;
        end else begin
          wr_part   = 1'b1;
          exp_idx_d = exp_idx_q + 3'd1;
          state_d   = WAIT_CHANGE;
        end
      end
      WAIT_CHANGE: begin
        if (sel_s != samp_sel_q) begin
          if (sel_s == exp_idx_q) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else begin
            frame_err_d = (exp_idx_q != 3'd0);
            clr_frame   = 1'b1;
            exp_idx_d   = '0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    frame_d = clr_frame ? '0 : (wr_part ? merged : frame_q);
    data_d  = load_out ? merged : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exp_idx_q   <= '0;
      samp_sel_q  <= '0;
      cnt_q       <= '0;
      frame_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      seg_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_idx_q   <= exp_idx_d;
      samp_sel_q  <= samp_sel_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      seg_err_q   <= seg_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign seg_err    = seg_err_q;
  assign frame_err  = frame_err_q;

`ifdef SEG_DP_CAPTURE_EN
  // Decimal points travel with the digits: partial dp bits, then an atomic copy with data_out.
  logic [5:0] dp_part_q, dp_out_q, dp_merged;

  always_comb begin
    dp_merged = dp_part_q;
    for (int i = 0; i < 6; i++)
      if (exp_idx_q == 3'(i)) dp_merged[5-i] = ~seg_dly_q[7];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_part_q <= '0;
      dp_out_q  <= '0;
    end else begin
      if (load_out) dp_out_q <= dp_merged;
      if (clr_frame)    dp_part_q <= '0;
      else if (wr_part) dp_part_q <= dp_merged;
    end
  end

  assign dp_out = dp_out_q;
`endif

endmodule
